tuner_seq_ctrl: RTL and testbench



---
 rtl/tuner_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_tuner_seq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tuner_seq_ctrl.sv
// tuner_seq_ctrl: top-level sequencer for the tuner datapath.
// Each measurement frame runs capture -> pitch analysis -> display -> hold,
// and repeats while enable_i is high. The block also owns the single-port
// sample RAM and hands it to the capture writer or to the analysis reader.
// Optional feature macro: WATCHDOG_EN adds a timeout on CAPTURE and ANALYZE
// that raises a sticky err_o and drops the frame back to IDLE.
//
// Handshake semantics (both sides):
//   cap_start_o is a level that stays high from the cycle after CAPTURE entry
//   until the cycle after cap_done_i is seen; cap_done_i is a 1-cycle pulse
//   that only counts in CAPTURE. ana_start_o is a 1-cycle pulse on the first
//   ANALYZE cycle; ana_done_i is a 1-cycle pulse that only counts in ANALYZE.
module tuner_seq_ctrl #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 10,
  parameter int NOTE_W      = 3,
  parameter int HOLD_CYC    = 262144,
  parameter int TIMEOUT_CYC = 2097152
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  output logic              cap_start_o,
  input  logic              cap_done_i,
  input  logic              cap_we_i,
  input  logic [ADDR_W-1:0] cap_addr_i,
  input  logic [DATA_W-1:0] cap_data_i,
  output logic              ana_start_o,
  input  logic              ana_done_i,
  input  logic [ADDR_W-1:0] ana_addr_i,
  input  logic [NOTE_W-1:0] ana_note_i,
  input  logic [DATA_W-1:0] ana_value_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [NOTE_W-1:0] disp_note_o,
  output logic [DATA_W-1:0] disp_value_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_ANALYZE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  // Hold counter is wide enough for HOLD_CYC-1; expiry is on its last value.
  localparam int          HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  state_t              state_q, state_d;
  logic                cap_start_q, cap_start_d;
  logic                ana_start_q, ana_start_d;
  logic [NOTE_W-1:0]   disp_note_q, disp_note_d;
  logic [DATA_W-1:0]   disp_value_q, disp_value_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

`ifdef WATCHDOG_EN
  localparam int        WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic                err_q, err_d;
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic                wd_expired;

  // Timeout fires on the TIMEOUT_CYC-th waiting cycle without a done pulse.
  assign wd_expired = (wd_cnt_q == WD_LAST);
  assign err_o      = err_q;
`else
  assign err_o      = 1'b0;
`endif

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    cap_start_d  = 1'b0;
    ana_start_d  = 1'b0;
    disp_note_d  = disp_note_q;
    disp_value_d = disp_value_q;
    hold_cnt_d   = '0;
`ifdef WATCHDOG_EN
    err_d        = err_q;
    wd_cnt_d     = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable_i) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (cap_done_i) begin
          state_d     = S_ANALYZE;
          ana_start_d = 1'b1;
        end else begin
          cap_start_d = 1'b1;
`ifdef WATCHDOG_EN
          if (wd_expired) begin
            state_d     = S_IDLE;
            cap_start_d = 1'b0;
            err_d       = 1'b1;
          end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
`endif
        end
      end
      S_ANALYZE: begin
        if (ana_done_i) begin
          state_d      = S_HOLD;
          disp_note_d  = ana_note_i;
          disp_value_d = ana_value_i;
`ifdef WATCHDOG_EN
          err_d        = 1'b0;
        end else if (wd_expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
`endif
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = enable_i ? S_CAPTURE : S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset overrides every event in the cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cap_start_q  <= 1'b0;
      ana_start_q  <= 1'b0;
      disp_note_q  <= '0;
      disp_value_q <= '0;
      hold_cnt_q   <= '0;
`ifdef WATCHDOG_EN
      err_q        <= 1'b0;
      wd_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cap_start_q  <= cap_start_d;
      ana_start_q  <= ana_start_d;
      disp_note_q  <= disp_note_d;
      disp_value_q <= disp_value_d;
      hold_cnt_q   <= hold_cnt_d;
`ifdef WATCHDOG_EN
      err_q        <= err_d;
      wd_cnt_q     <= wd_cnt_d;
`endif
    end
  end

  // Sample RAM port: writer owns it in CAPTURE, reader in ANALYZE, else parked.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      S_CAPTURE: begin
        mem_we_o    = cap_we_i;
        mem_addr_o  = cap_addr_i;
        mem_wdata_o = cap_data_i;
      end
      S_ANALYZE: begin
        mem_addr_o  = ana_addr_i;
      end
      default: ;
    endcase
  end

  assign cap_start_o  = cap_start_q;
  assign ana_start_o  = ana_start_q;
  assign disp_note_o  = disp_note_q;
  assign disp_value_o = disp_value_q;
  assign busy_o       = (state_q != S_IDLE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_tuner_seq_ctrl.sv
// Bench for tuner_seq_ctrl with a short hold (8) and timeout (16).
module tb_tuner_seq_ctrl;

  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 10;
  localparam int NOTE_W  = 3;
  localparam int HOLD_C  = 8;
  localparam int TOUT_C  = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_ANALYZE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, enable;
  logic              cap_start, cap_done, cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic              ana_start, ana_done;
  logic [ADDR_W-1:0] ana_addr;
  logic [NOTE_W-1:0] ana_note;
  logic [DATA_W-1:0] ana_value;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NOTE_W-1:0] disp_note;
  logic [DATA_W-1:0] disp_value;
  logic              busy, err;
  logic [1:0]        state;

  tuner_seq_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOTE_W(NOTE_W),
    .HOLD_CYC(HOLD_C), .TIMEOUT_CYC(TOUT_C)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable),
    .cap_start_o(cap_start), .cap_done_i(cap_done), .cap_we_i(cap_we),
    .cap_addr_i(cap_addr), .cap_data_i(cap_data),
    .ana_start_o(ana_start), .ana_done_i(ana_done), .ana_addr_i(ana_addr),
    .ana_note_i(ana_note), .ana_value_i(ana_value),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .disp_note_o(disp_note), .disp_value_o(disp_value),
    .busy_o(busy), .err_o(err), .state_o(state)
  );

  // scoreboard
  localparam int MW = 1 + ADDR_W + DATA_W;
  localparam int DW = NOTE_W + DATA_W;
  logic [MW-1:0] exp_q[$];
  logic [DW-1:0] disp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
  } mux_vec_t;

  mux_vec_t cap_vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem(input string name);
    logic [MW-1:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'({mem_we, mem_addr, mem_wdata}), 32'(e));
    end
  endtask

  task automatic check_disp(input string name);
    logic [DW-1:0] e;
    if (disp_q.size() == 0) begin
      check({name, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = disp_q.pop_front();
      check(name, 32'({disp_note, disp_value}), 32'(e));
    end
  endtask

  // Pulse ana_done with a result and push the expected display value.
  task automatic do_ana_done(input logic [NOTE_W-1:0] n, input logic [DATA_W-1:0] v);
    ana_done = 1'b1; ana_note = n; ana_value = v;
    disp_q.push_back({n, v});
    step();
    ana_done = 1'b0;
  endtask

  task automatic pulse_cap_done();
    cap_done = 1'b1;
    step();
    cap_done = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cnt;
    rst = 1'b1; enable = 1'b1;
    cap_done = 1'b0; cap_we = 1'b0; cap_addr = '0; cap_data = '0;
    ana_done = 1'b0; ana_addr = '0; ana_note = '0; ana_value = '0;

    cap_vecs[0] = '{1'b1, 11'd5,    10'(-3),  1'b1, 11'd5,    10'(-3)};
    cap_vecs[1] = '{1'b0, 11'd2047, 10'd511,  1'b0, 11'd2047, 10'd511};
    cap_vecs[2] = '{1'b1, 11'd0,    10'(-512),1'b1, 11'd0,    10'(-512)};
    for (int i = 3; i < 6; i++) begin
      cap_vecs[i].we   = 1'($urandom_range(0, 1));
      cap_vecs[i].addr = 11'($urandom_range(0, 2047));
      cap_vecs[i].data = 10'($urandom_range(0, 1023));
      cap_vecs[i].exp_we   = cap_vecs[i].we;
      cap_vecs[i].exp_addr = cap_vecs[i].addr;
      cap_vecs[i].exp_data = cap_vecs[i].data;
    end

    // reset with enable high
    repeat (3) step();
    check("rst_cap_start", 32'(cap_start), 32'd0);
    check("rst_ana_start", 32'(ana_start), 32'd0);
    check("rst_mem", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
    check("rst_disp", 32'({disp_note, disp_value}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(state), 32'(ST_IDLE));

    rst = 1'b0;
    step();
    check("cap_entry_state", 32'(state), 32'(ST_CAPTURE));
    check("cap_entry_start", 32'(cap_start), 32'd0);
    step();
    check("cap_start_2cyc", 32'(cap_start), 32'd1);

    // RAM mux in CAPTURE
    for (int i = 0; i < 6; i++) begin
      cap_we = cap_vecs[i].we; cap_addr = cap_vecs[i].addr; cap_data = cap_vecs[i].data;
      exp_q.push_back({cap_vecs[i].exp_we, cap_vecs[i].exp_addr, cap_vecs[i].exp_data});
      #1;
      check_mem("mux_capture");
      step();
      check("cap_start_held", 32'(cap_start), 32'd1);
    end

    // ana_done is ignored in CAPTURE
    do_ana_done(3'd7, 10'd99);
    void'(disp_q.pop_back());
    check("spur_ana_in_cap_state", 32'(state), 32'(ST_CAPTURE));
    check("spur_ana_in_cap_disp", 32'({disp_note, disp_value}), 32'd0);

    // capture done -> analyze
    pulse_cap_done();
    check("done_cap_start_low", 32'(cap_start), 32'd0);
    check("ana_start_pulse", 32'(ana_start), 32'd1);
    check("ana_state", 32'(state), 32'(ST_ANALYZE));
    cap_we = 1'b1; cap_addr = 11'd5; cap_data = 10'(-3); ana_addr = 11'd77;
    exp_q.push_back({1'b0, 11'd77, 10'd0});
    #1;
    check_mem("mux_analyze");
    step();
    check("ana_start_one_cycle", 32'(ana_start), 32'd0);
    cap_we = 1'b0;

    // analysis result then hold
    do_ana_done(3'd4, 10'd17);
    check_disp("disp_first");
    check("hold_state", 32'(state), 32'(ST_HOLD));
    cnt = 1;
    while (!cap_start && cnt < 40) begin
      if (cnt == 3) begin
        cap_done = 1'b1; ana_done = 1'b1; ana_note = 3'd1; ana_value = 10'd55;
      end else begin
        cap_done = 1'b0; ana_done = 1'b0;
      end
      step();
      cnt++;
    end
    cap_done = 1'b0; ana_done = 1'b0;
    check("hold_restart_cycles", 32'(cnt >= HOLD_C + 1 && cnt <= HOLD_C + 2), 32'd1);
    check("hold_spur_disp", 32'({disp_note, disp_value}), 32'({3'd4, 10'd17}));

    // second frame, enable dropped -> back to IDLE after hold
    pulse_cap_done();
    enable = 1'b0;
    do_ana_done(3'd2, 10'(-100));
    check_disp("disp_second");
    cnt = 0;
    while (busy && cnt < 40) begin
      step();
      cnt++;
    end
    check("hold_to_idle_cycles", 32'(cnt), 32'(HOLD_C));
    check("idle_cap_start", 32'(cap_start), 32'd0);

    // spurious dones in IDLE
    cap_done = 1'b1; ana_done = 1'b1; ana_note = 3'd5; ana_value = 10'd3;
    step();
    cap_done = 1'b0; ana_done = 1'b0;
    step();
    check("idle_spur_state", 32'(state), 32'(ST_IDLE));
    check("idle_spur_disp", 32'({disp_note, disp_value}), 32'({3'd2, 10'(-100)}));

    // cap_done on the very first CAPTURE cycle; enable dropped mid-frame
    enable = 1'b1;
    step();
    enable = 1'b0;
    pulse_cap_done();
    check("coincide_cap_start", 32'(cap_start), 32'd0);
    check("coincide_ana_start", 32'(ana_start), 32'd1);
    do_ana_done(3'd6, 10'd300);
    check_disp("disp_third");
    cnt = 0;
    while (busy && cnt < 40) begin
      step();
      cnt++;
    end
    check("midframe_drop_idle", 32'(state), 32'(ST_IDLE));

    // reset in the middle of ANALYZE, coinciding with ana_done
    enable = 1'b1;
    step();
    step();
    pulse_cap_done();
    enable = 1'b0;
    rst = 1'b1; ana_done = 1'b1; ana_note = 3'd1; ana_value = 10'd1;
    step();
    rst = 1'b0; ana_done = 1'b0;
    check("midrst_state", 32'(state), 32'(ST_IDLE));
    check("midrst_disp", 32'({disp_note, disp_value}), 32'd0);
    check("midrst_ana_start", 32'(ana_start), 32'd0);
    step();
    check("midrst_busy", 32'(busy), 32'd0);

`ifdef WATCHDOG_EN
    // capture with no cap_done times out
    enable = 1'b1;
    cnt = 0;
    while (!err && cnt < 100) begin
      step();
      cnt++;
    end
    check("wd_cycles", 32'(cnt), 32'(TOUT_C + 1));
    check("wd_idle", 32'(state), 32'(ST_IDLE));
    check("wd_cap_start", 32'(cap_start), 32'd0);
    check("wd_disp_kept", 32'({disp_note, disp_value}), 32'd0);
    step();
    pulse_cap_done();
    check("wd_err_sticky", 32'(err), 32'd1);
    do_ana_done(3'd3, 10'd9);
    check_disp("disp_after_wd");
    check("wd_err_cleared", 32'(err), 32'd0);
`else
    enable = 1'b1;
    repeat (40) step();
    check("nowd_err", 32'(err), 32'd0);
    check("nowd_waiting", 32'(state), 32'(ST_CAPTURE));
    check("nowd_cap_start", 32'(cap_start), 32'd1);
`endif

    check("scoreboard_drained", 32'(exp_q.size() + disp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
